rx_timer: RTL



---
 rtl/uart_rx_pkg.sv | 13 +
 rtl/flex_counter.sv | 43 ++++
 rtl/rx_timer.sv | 55 +++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path.
// Frame length helper adds the single stop bit to the data bit count.
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_SAMPLE_POINT = 2;
  localparam int UART_DATA_BITS    = 8;

  function automatic int frame_bits(input int data_bits);
    return data_bits + 1;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable rollover back to 1.
// rollover_flag is a level that is high while the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Clear beats count; a full count wraps to 1 so 0 only ever means "idle".
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// UART receive bit-timing generator: one shift strobe per bit at the sample
// point, then packet_done held until the controller drops enable_timer.
module rx_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = UART_SAMPLE_POINT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  output logic shift_strobe,
  output logic packet_done
);

  localparam int NUM_BITS = frame_bits(DATA_BITS);
  localparam int CLK_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W    = $clog2(NUM_BITS + 1);

  logic [CLK_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             clk_wrap_unused;

  // The clock counter freezes once the frame is complete.
  flex_counter #(
    .NUM_CNT_BITS(CLK_W)
  ) u_clk_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!enable_timer),
    .count_enable (enable_timer && !packet_done),
    .rollover_val (CLK_W'(CLKS_PER_BIT)),
    .count_out    (clk_cnt),
    .rollover_flag(clk_wrap_unused)
  );

  // Strobes stop at NUM_BITS, so this counter saturates rather than wrapping.
  flex_counter #(
    .NUM_CNT_BITS(BIT_W)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!enable_timer),
    .count_enable (shift_strobe),
    .rollover_val (BIT_W'(NUM_BITS)),
    .count_out    (bit_cnt),
    .rollover_flag(packet_done)
  );

  assign shift_strobe = enable_timer
                     && (clk_cnt == CLK_W'(SAMPLE_POINT))
                     && (bit_cnt < BIT_W'(NUM_BITS));

endmodule
